// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-slot alarm setter.
// Cursor one-hot positions, digit limits, the BCD time struct and the FSM state type.
package alarm_pkg;

    // One-hot cursor positions, MSB = hour tens.
    localparam logic [5:0] CUR_HT = 6'b100000;
    localparam logic [5:0] CUR_HU = 6'b010000;
    localparam logic [5:0] CUR_MT = 6'b001000;
    localparam logic [5:0] CUR_MU = 6'b000100;
    localparam logic [5:0] CUR_ST = 6'b000010;
    localparam logic [5:0] CUR_SU = 6'b000001;

    // Digit upper limits.
    localparam logic [3:0] MAX_HT    = 4'd2;
    localparam logic [3:0] MAX_HU    = 4'd9;
    localparam logic [3:0] MAX_HU_20 = 4'd3;
    localparam logic [3:0] MAX_TENS  = 4'd5;
    localparam logic [3:0] MAX_UNITS = 4'd9;

    typedef struct packed {
        logic [3:0] ht;
        logic [3:0] hu;
        logic [3:0] mt;
        logic [3:0] mu;
        logic [3:0] st;
        logic [3:0] su;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = '0;

    typedef enum logic [0:0] {
        StIdle,
        StEdit
    } state_t;

    // Largest legal value of the digit under the cursor; hour units depend on hour tens.
    function automatic logic [3:0] digit_max(input logic [5:0] cur, input logic [3:0] ht);
        logic [3:0] m;
        m = MAX_UNITS;
        case (cur)
            CUR_HT:  m = MAX_HT;
            CUR_HU:  m = (ht == MAX_HT) ? MAX_HU_20 : MAX_HU;
            CUR_MT:  m = MAX_TENS;
            CUR_ST:  m = MAX_TENS;
            default: m = MAX_UNITS;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational increment/decrement of one BCD digit with wrap at its limit.
// The limit is chosen from the cursor position and, for hour units, the hour tens digit.
module bcd_digit_step
    import alarm_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_up,
    input  logic [5:0] i_cursor,
    input  logic [3:0] i_hour_tens,
    output logic [3:0] o_digit
);

    logic [3:0] w_max;

    assign w_max = digit_max(i_cursor, i_hour_tens);

    // Wrap past the limit upward to 0, and below 0 to the limit.
    always_comb begin
        o_digit = i_digit;
        if (i_up) begin
            o_digit = (i_digit >= w_max) ? 4'd0 : i_digit + 4'd1;
        end else begin
            o_digit = (i_digit == 4'd0 || i_digit > w_max) ? w_max : i_digit - 4'd1;
        end
    end

endmodule

// File: rtl/multi_alarm_setting.sv
// Multi-slot HH:MM:SS alarm setter with cursor/increase/decrease editing.
// Optional feature macro: ALARM_SECONDS_EN (seconds digits editable; otherwise forced to 0).
module multi_alarm_setting
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int SLOT_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    switch_set_alarm,
    input  logic                    button_left,
    input  logic                    button_right,
    input  logic                    button_increase,
    input  logic                    button_decrease,
    input  logic                    button_confirm,
    input  logic                    button_cancel,
    input  logic                    button_next_slot,
    output logic [23:0]             alarm_display,
    output logic [5:0]              blinking_pattern,
    output logic [SLOT_W-1:0]       alarm_slot,
    output logic [24*NUM_ALARMS-1:0] alarm_times,
    output logic [NUM_ALARMS-1:0]   alarm_enable,
    output logic                    editing
);

    // Button bit order is also the priority order, bit 0 highest.
    localparam int A_CONFIRM = 0;
    localparam int A_CANCEL  = 1;
    localparam int A_RIGHT   = 2;
    localparam int A_LEFT    = 3;
    localparam int A_INC     = 4;
    localparam int A_DEC     = 5;
    localparam int A_NEXT    = 6;

`ifdef ALARM_SECONDS_EN
    localparam logic [5:0] CUR_LAST = CUR_SU;
`else
    localparam logic [5:0] CUR_LAST = CUR_MU;
`endif

    state_t          r_state, w_state_d;
    bcd_time_t       r_buf, w_buf_d;
    bcd_time_t       r_slots [NUM_ALARMS];
    bcd_time_t       w_slots_d [NUM_ALARMS];
    logic [5:0]      r_cur, w_cur_d;
    logic [SLOT_W-1:0] r_slot, w_slot_d;
    logic [NUM_ALARMS-1:0] r_en, w_en_d;
    logic [6:0]      r_btn_prev;
    logic [6:0]      w_btn, w_rise, w_act;
    logic [23:0]     r_display, w_display_d;
    logic [5:0]      r_blink, w_blink_d;
    logic [3:0]      w_sel_digit, w_step_digit;

    assign w_btn  = {button_next_slot, button_decrease, button_increase, button_left,
                     button_right, button_cancel, button_confirm};
    assign w_rise = w_btn & ~r_btn_prev;

    // Keep only the highest-priority rising edge.
    always_comb begin
        w_act = '0;
        for (int i = 0; i < 7; i++) begin
            if (w_rise[i] && (w_act == '0)) begin
                w_act[i] = 1'b1;
            end
        end
    end

    // Pick the buffer digit under the cursor for the shared stepper.
    always_comb begin
        w_sel_digit = 4'd0;
        unique case (r_cur)
            CUR_HT:  w_sel_digit = r_buf.ht;
            CUR_HU:  w_sel_digit = r_buf.hu;
            CUR_MT:  w_sel_digit = r_buf.mt;
            CUR_MU:  w_sel_digit = r_buf.mu;
            CUR_ST:  w_sel_digit = r_buf.st;
            CUR_SU:  w_sel_digit = r_buf.su;
            default: w_sel_digit = 4'd0;
        endcase
    end

    bcd_digit_step u_step (
        .i_digit     (w_sel_digit),
        .i_up        (w_act[A_INC]),
        .i_cursor    (r_cur),
        .i_hour_tens (r_buf.ht),
        .o_digit     (w_step_digit)
    );

    // Next-state for the FSM, edit buffer, cursor, slot select and stored slots.
    always_comb begin
        w_state_d = r_state;
        w_buf_d   = r_buf;
        w_cur_d   = r_cur;
        w_slot_d  = r_slot;
        w_en_d    = r_en;
        w_slots_d = r_slots;
        unique case (r_state)
            StIdle: begin
                if (switch_set_alarm) begin
                    // Entry load wins over any coincident button edge.
                    w_state_d = StEdit;
                    w_buf_d   = r_slots[r_slot];
                    w_cur_d   = CUR_HT;
                end else if (w_act[A_CANCEL]) begin
                    w_slots_d[r_slot] = TIME_ZERO;
                    w_en_d[r_slot]    = 1'b0;
                end else if (w_act[A_NEXT]) begin
                    w_slot_d = (r_slot == SLOT_W'(NUM_ALARMS - 1)) ? '0 : r_slot + 1'b1;
                end
            end
            StEdit: begin
                if (!switch_set_alarm) begin
                    w_state_d = StIdle;
                end else if (w_act[A_CONFIRM]) begin
                    w_slots_d[r_slot] = r_buf;
                    w_en_d[r_slot]    = 1'b1;
                end else if (w_act[A_CANCEL]) begin
                    w_buf_d = TIME_ZERO;
                end else if (w_act[A_RIGHT]) begin
                    w_cur_d = (r_cur == CUR_LAST) ? CUR_HT : (r_cur >> 1);
                end else if (w_act[A_LEFT]) begin
                    w_cur_d = (r_cur == CUR_HT) ? CUR_LAST : (r_cur << 1);
                end else if (w_act[A_INC] || w_act[A_DEC]) begin
                    unique case (r_cur)
                        CUR_HT:  w_buf_d.ht = w_step_digit;
                        CUR_HU:  w_buf_d.hu = w_step_digit;
                        CUR_MT:  w_buf_d.mt = w_step_digit;
                        CUR_MU:  w_buf_d.mu = w_step_digit;
                        CUR_ST:  w_buf_d.st = w_step_digit;
                        CUR_SU:  w_buf_d.su = w_step_digit;
                        default: w_buf_d    = r_buf;
                    endcase
                    // Reaching 2x with hour units above 3 would be an illegal hour.
                    if (r_cur == CUR_HT && w_buf_d.ht == MAX_HT && w_buf_d.hu > MAX_HU_20) begin
                        w_buf_d.hu = 4'd0;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
`ifndef ALARM_SECONDS_EN
        w_buf_d.st = 4'd0;
        w_buf_d.su = 4'd0;
        for (int k = 0; k < NUM_ALARMS; k++) begin
            w_slots_d[k].st = 4'd0;
            w_slots_d[k].su = 4'd0;
        end
`endif
    end

    // Output views computed from next state so they register on the same edge.
    always_comb begin
        w_display_d = w_slots_d[w_slot_d];
        w_blink_d   = 6'b000000;
        if (w_state_d == StEdit) begin
            w_display_d = w_buf_d;
            w_blink_d   = w_cur_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_buf      <= TIME_ZERO;
            r_cur      <= CUR_HT;
            r_slot     <= '0;
            r_en       <= '0;
            r_btn_prev <= '0;
            r_display  <= '0;
            r_blink    <= '0;
            for (int k = 0; k < NUM_ALARMS; k++) begin
                r_slots[k] <= TIME_ZERO;
            end
        end else begin
            r_state    <= w_state_d;
            r_buf      <= w_buf_d;
            r_cur      <= w_cur_d;
            r_slot     <= w_slot_d;
            r_en       <= w_en_d;
            r_btn_prev <= w_btn;
            r_display  <= w_display_d;
            r_blink    <= w_blink_d;
            for (int k = 0; k < NUM_ALARMS; k++) begin
                r_slots[k] <= w_slots_d[k];
            end
        end
    end

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_times
        assign alarm_times[24*g +: 24] = r_slots[g];
    end

    assign alarm_display    = r_display;
    assign blinking_pattern = r_blink;
    assign alarm_slot       = r_slot;
    assign alarm_enable     = r_en;
    assign editing          = (r_state == StEdit);

endmodule
